// File: rtl/icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm
//   Direct-mapped, read-only instruction cache. It sits between the
//   instruction fetch unit and the AXI master's rw_* request port. Hits are
//   served from internal flop arrays. A miss refills the whole line with one
//   INCR burst and then serves the fetch from the freshly filled line.
//   fence.i invalidates every line at once.
//
// Ports
//   clk, rst           : clock and synchronous active-high reset
//   ifu_req_*          : fetch request (address bits [1:0] ignored)
//   ifu_resp_*         : 32-bit instruction response
//   fence_valid/ready  : invalidate-all handshake
//   mem_addr_*         : refill burst request (line-aligned address)
//   mem_we/if/len/size/burst : fixed attributes of the refill burst
//   mem_r_*            : refill read-data beats
// ---------------------------------------------------------------------------
module icache_dm #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BEATS = 2,
  parameter int SETS       = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [31:0]           ifu_inst,
  input  logic                  fence_valid,
  output logic                  fence_ready,
  output logic                  mem_addr_valid,
  input  logic                  mem_addr_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_if,
  output logic [7:0]            mem_len,
  output logic [2:0]            mem_size,
  output logic [1:0]            mem_burst,
  input  logic                  mem_r_valid,
  output logic                  mem_r_ready,
  input  logic [DATA_WIDTH-1:0] mem_r_data
);

  localparam int OFF_W  = $clog2(8 * LINE_BEATS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOOKUP  = 2'd1;
  localparam logic [1:0] S_MISS_AR = 2'd2;
  localparam logic [1:0] S_MISS_R  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [BEAT_W-1:0]     cnt_q, cnt_d;
  logic [SETS-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q [SETS];
  logic [TAG_W-1:0]      tag_d [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS][LINE_BEATS];
  logic [DATA_WIDTH-1:0] data_d [SETS][LINE_BEATS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [BEAT_W-1:0]     beat;
  logic                  half;
  logic                  hit;
  logic [DATA_WIDTH-1:0] line_word;

  // Address fields of the registered request. The index and tag always come
  // from req_addr_q, so the lookup and the refill target the same line.
  always_comb begin
    idx       = IDX_W'(req_addr_q >> OFF_W);
    tag       = TAG_W'(req_addr_q >> (OFF_W + IDX_W));
    beat      = (LINE_BEATS > 1) ? BEAT_W'(req_addr_q >> 3) : '0;
    half      = req_addr_q[2];
    hit       = valid_q[idx] && (tag_q[idx] == tag);
    line_word = data_q[idx][beat];
  end

  // Burst attributes never change: instruction fetch, read, full 8-byte
  // beats, incrementing addresses, one whole line per burst.
  assign mem_we    = 1'b0;
  assign mem_if    = 1'b1;
  assign mem_len   = 8'(LINE_BEATS - 1);
  assign mem_size  = 3'b011;
  assign mem_burst = 2'b01;
  assign mem_addr  = {req_addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  // Main control: handshakes, next-state and array write-enables. A fence in
  // IDLE takes priority over a simultaneous fetch, which simply retries next
  // cycle. The last refill beat validates the line and drops back into
  // LOOKUP so the ordinary hit path delivers the instruction.
  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    cnt_d          = cnt_q;
    valid_d        = valid_q;
    tag_d          = tag_q;
    data_d         = data_q;
    ifu_req_ready  = 1'b0;
    fence_ready    = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_inst       = 32'h0;
    mem_addr_valid = 1'b0;
    mem_r_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        fence_ready   = 1'b1;
        ifu_req_ready = !fence_valid;
        if (fence_valid) begin
          valid_d = '0;
        end else if (ifu_req_valid) begin
          req_addr_d = ifu_addr;
          state_d    = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          ifu_resp_valid = 1'b1;
          ifu_inst       = half ? line_word[63:32] : line_word[31:0];
          if (ifu_resp_ready) begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_MISS_AR;
        end
      end

      S_MISS_AR: begin
        mem_addr_valid = 1'b1;
        cnt_d          = '0;
        if (mem_addr_ready) begin
          state_d = S_MISS_R;
        end
      end

      S_MISS_R: begin
        mem_r_ready = 1'b1;
        if (mem_r_valid) begin
          data_d[idx][cnt_q] = mem_r_data;
          cnt_d              = cnt_q + 1'b1;
          if (cnt_q == BEAT_W'(LINE_BEATS - 1)) begin
            valid_d[idx] = 1'b1;
            tag_d[idx]   = tag;
            state_d      = S_LOOKUP;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control flops with synchronous reset. Clearing valid_q on reset is what
  // keeps a half-filled line from ever hitting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      cnt_q      <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; their contents only matter once the
  // matching valid bit is set.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_icache_dm.sv
// ---------------------------------------------------------------------------
// tb_icache_dm
//   Directed testbench for icache_dm with the default geometry (64 sets,
//   16-byte lines). Expected instructions and refill addresses are worked
//   out by hand from the beat patterns written into memory.
// ---------------------------------------------------------------------------
module tb_icache_dm;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_inst;
  logic        fence_valid;
  logic        fence_ready;
  logic        mem_addr_valid;
  logic        mem_addr_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic        mem_if;
  logic [7:0]  mem_len;
  logic [2:0]  mem_size;
  logic [1:0]  mem_burst;
  logic        mem_r_valid;
  logic        mem_r_ready;
  logic [63:0] mem_r_data;

  int nVectors;
  int nMiscompares;

  icache_dm dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_inst       (ifu_inst),
    .fence_valid    (fence_valid),
    .fence_ready    (fence_ready),
    .mem_addr_valid (mem_addr_valid),
    .mem_addr_ready (mem_addr_ready),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_if         (mem_if),
    .mem_len        (mem_len),
    .mem_size       (mem_size),
    .mem_burst      (mem_burst),
    .mem_r_valid    (mem_r_valid),
    .mem_r_ready    (mem_r_ready),
    .mem_r_data     (mem_r_data)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the design wedges somewhere no bounded wait covers.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every vector and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a fetch and hold it until the cache takes it (bounded wait).
  // Returns just after the accepting edge with the request withdrawn.
  task automatic applyStimulus(input logic [31:0] addr);
    ifu_req_valid = 1'b1;
    ifu_addr      = addr;
    #1;
    for (int i = 0; i < 20 && !ifu_req_ready; i++) cyc();
    checkOutput("req_ready", {63'd0, ifu_req_ready}, 64'd1);
    cyc();
    ifu_req_valid = 1'b0;
    #1;
  endtask

  // Wait (bounded) for the refill request, check its address and attributes,
  // accept it, then stream two beats.
  task automatic serveRefill(input logic [31:0] expAddr, input logic [63:0] b0, input logic [63:0] b1);
    for (int i = 0; i < 20 && !mem_addr_valid; i++) cyc();
    checkOutput("ar_valid", {63'd0, mem_addr_valid}, 64'd1);
    checkOutput("ar_addr",  {32'd0, mem_addr}, {32'd0, expAddr});
    mem_addr_ready = 1'b1;
    cyc();
    mem_addr_ready = 1'b0;
    #1;
    checkOutput("r_ready", {63'd0, mem_r_ready}, 64'd1);
    mem_r_valid = 1'b1;
    mem_r_data  = b0;
    cyc();
    mem_r_data  = b1;
    #1;
    checkOutput("resp_before_last", {63'd0, ifu_resp_valid}, 64'd0);
    cyc();
    mem_r_valid = 1'b0;
    mem_r_data  = '0;
    #1;
  endtask

  // Check the pending response and retire it.
  task automatic takeResponse(input string tag, input logic [31:0] expInst);
    checkOutput({tag, "_valid"}, {63'd0, ifu_resp_valid}, 64'd1);
    checkOutput({tag, "_inst"}, {32'd0, ifu_inst}, {32'd0, expInst});
    ifu_resp_ready = 1'b1;
    cyc();
    ifu_resp_ready = 1'b0;
    #1;
    checkOutput({tag, "_done"}, {63'd0, ifu_resp_valid}, 64'd0);
  endtask

  initial begin
    nVectors       = 0;
    nMiscompares   = 0;
    rst            = 1'b1;
    ifu_req_valid  = 1'b0;
    ifu_addr       = '0;
    ifu_resp_ready = 1'b0;
    fence_valid    = 1'b0;
    mem_addr_ready = 1'b0;
    mem_r_valid    = 1'b0;
    mem_r_data     = '0;

    // Reset values.
    repeat (3) cyc();
    checkOutput("rst_resp_valid", {63'd0, ifu_resp_valid}, 64'd0);
    checkOutput("rst_ar_valid",   {63'd0, mem_addr_valid}, 64'd0);
    checkOutput("rst_r_ready",    {63'd0, mem_r_ready},    64'd0);
    checkOutput("rst_inst",       {32'd0, ifu_inst},       64'd0);
    rst = 1'b0;
    cyc();
    checkOutput("rst_req_ready",   {63'd0, ifu_req_ready}, 64'd1);
    checkOutput("rst_fence_ready", {63'd0, fence_ready},   64'd1);

    // Cold miss on 0x8000_0004: upper half of beat 0.
    $display("[TB] cold miss");
    applyStimulus(32'h8000_0004);
    checkOutput("cold_lookup_miss", {63'd0, ifu_resp_valid}, 64'd0);
    cyc();
    checkOutput("cold_len",   {56'd0, mem_len},   64'd1);
    checkOutput("cold_size",  {61'd0, mem_size},  64'd3);
    checkOutput("cold_burst", {62'd0, mem_burst}, 64'd1);
    checkOutput("cold_if",    {63'd0, mem_if},    64'd1);
    checkOutput("cold_we",    {63'd0, mem_we},    64'd0);
    serveRefill(32'h8000_0000, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    takeResponse("cold", 32'h1111_2222);

    // Hit on 0x8000_0008: lower half of beat 1, one cycle after acceptance.
    $display("[TB] hit");
    applyStimulus(32'h8000_0008);
    checkOutput("hit_no_ar", {63'd0, mem_addr_valid}, 64'd0);
    takeResponse("hit", 32'h7777_8888);

    // Conflict: 0x8000_0400 shares index 0 with a different tag.
    $display("[TB] conflict");
    applyStimulus(32'h8000_0400);
    checkOutput("conf_lookup_miss", {63'd0, ifu_resp_valid}, 64'd0);
    serveRefill(32'h8000_0400, 64'hAAAA_0000_BBBB_0001, 64'hCCCC_0002_DDDD_0003);
    takeResponse("conf", 32'hBBBB_0001);
    applyStimulus(32'h8000_0000);
    checkOutput("conf_back_miss", {63'd0, ifu_resp_valid}, 64'd0);
    serveRefill(32'h8000_0000, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    takeResponse("conf_back", 32'h3333_4444);

    // Fence together with a fetch: fence wins, fetch goes next cycle and misses.
    $display("[TB] fence");
    fence_valid   = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    #1;
    checkOutput("fence_ready", {63'd0, fence_ready},   64'd1);
    checkOutput("fence_block", {63'd0, ifu_req_ready}, 64'd0);
    cyc();
    fence_valid = 1'b0;
    applyStimulus(32'h8000_0000);
    checkOutput("fence_miss", {63'd0, ifu_resp_valid}, 64'd0);
    cyc();

    // Address backpressure on this refill: request held and address stable.
    $display("[TB] backpressure");
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_ar_valid", {63'd0, mem_addr_valid}, 64'd1);
      checkOutput("bp_ar_addr",  {32'd0, mem_addr},       64'h8000_0000);
      cyc();
    end
    serveRefill(32'h8000_0000, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);

    // Response backpressure with a competing fetch that must not be taken.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0008;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("rbp_valid",     {63'd0, ifu_resp_valid}, 64'd1);
      checkOutput("rbp_inst",      {32'd0, ifu_inst},       64'h89AB_CDEF);
      checkOutput("rbp_req_block", {63'd0, ifu_req_ready},  64'd0);
      cyc();
    end
    ifu_req_valid = 1'b0;
    takeResponse("rbp", 32'h89AB_CDEF);

    // Reset after the first beat of a refill of 0x8000_0010 (index 1).
    $display("[TB] reset mid-refill");
    applyStimulus(32'h8000_0010);
    for (int i = 0; i < 20 && !mem_addr_valid; i++) cyc();
    checkOutput("mr_ar_valid", {63'd0, mem_addr_valid}, 64'd1);
    mem_addr_ready = 1'b1;
    cyc();
    mem_addr_ready = 1'b0;
    mem_r_valid    = 1'b1;
    mem_r_data     = 64'hDEAD_BEEF_CAFE_F00D;
    cyc();
    mem_r_valid = 1'b0;
    rst         = 1'b1;
    cyc();
    checkOutput("mr_resp_valid", {63'd0, ifu_resp_valid}, 64'd0);
    checkOutput("mr_ar_valid0",  {63'd0, mem_addr_valid}, 64'd0);
    checkOutput("mr_r_ready",    {63'd0, mem_r_ready},    64'd0);
    checkOutput("mr_inst",       {32'd0, ifu_inst},       64'd0);
    rst = 1'b0;
    cyc();
    checkOutput("mr_req_ready",   {63'd0, ifu_req_ready}, 64'd1);
    checkOutput("mr_fence_ready", {63'd0, fence_ready},   64'd1);
    applyStimulus(32'h8000_0010);
    checkOutput("mr_refetch_miss", {63'd0, ifu_resp_valid}, 64'd0);
    serveRefill(32'h8000_0010, 64'h1357_9BDF_2468_ACE0, 64'h0F0F_0F0F_F0F0_F0F0);
    takeResponse("mr", 32'h2468_ACE0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the IFU and the AXI master's rw_* request port.
- Hits return a 32-bit instruction from internal flop arrays.
- Misses issue one INCR burst refill of a whole line (rw_if=1, rw_we=0) and then serve the request from the refilled line.
- fence.i invalidates all lines.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 64, refill beat width; fixed at 64.
- LINE_BEATS, 2, 64-bit beats per line; power of 2; line bytes = 8*LINE_BEATS.
- SETS, 64, number of lines; power of 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- ifu_req_valid  in  1  fetch request.
- ifu_req_ready  out  1  cache can accept a request.
- ifu_addr  in  ADDR_WIDTH  fetch address; bits [1:0] ignored.
- ifu_resp_valid  out  1  instruction valid.
- ifu_resp_ready  in  1  IFU accepts instruction.
- ifu_inst  out  32  instruction.
- fence_valid  in  1  invalidate-all request.
- fence_ready  out  1  invalidate accepted.
- mem_addr_valid  out  1  refill request (to rw_addr_valid).
- mem_addr_ready  in  1  from rw_addr_ready.
- mem_addr  out  ADDR_WIDTH  line-aligned refill address.
- mem_we  out  1  constant 0.
- mem_if  out  1  constant 1.
- mem_len  out  8  LINE_BEATS-1.
- mem_size  out  3  constant 3'b011 (8 bytes).
- mem_burst  out  2  constant 2'b01 (INCR).
- mem_r_valid  in  1  refill beat valid (from r_data_valid).
- mem_r_ready  out  1  refill beat accept (to r_data_ready).
- mem_r_data  in  DATA_WIDTH  refill beat data.

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk.
- Address split:
  - off = addr[log2(8*LINE_BEATS)-1:0]
  - beat = addr[log2(8*LINE_BEATS)-1:3]
  - half = addr[2]
  - idx = next log2(SETS) bits
  - tag = the remaining upper bits
- Storage:
  - valid[SETS] flops; only these are cleared by reset or fence.
  - tag[SETS] array.
  - data[SETS][LINE_BEATS] x 64 array.
  - All storage is read combinationally.
- States:
  - IDLE: ifu_req_ready=1 and fence_ready=1.
    - fence_valid has priority: if fence_valid=1, ifu_req_ready=0 that cycle; fence handshake clears all valid bits at the next edge and the FSM stays in IDLE.
    - Otherwise ifu_req_valid&ifu_req_ready registers the address into req_addr and goes to LOOKUP.
  - LOOKUP: hit = valid[idx] & tag match.
    - Hit: ifu_resp_valid=1 and ifu_inst = half ? data[idx][beat][63:32] : [31:0]. The FSM stays in LOOKUP until ifu_resp_ready, then goes to IDLE.
    - Miss: go to MISS_AR.
    - Hit latency is 1 cycle from acceptance to resp_valid.
  - MISS_AR: mem_addr_valid=1 with mem_addr = req_addr with off bits zeroed. The fill counter is cleared. On mem_addr_valid&mem_addr_ready, go to MISS_R.
  - MISS_R: mem_r_ready=1.
    - Each mem_r_valid&mem_r_ready writes mem_r_data to data[idx][cnt] and increments cnt.
    - On the beat where cnt==LINE_BEATS-1: set valid[idx]=1, write tag[idx], and go to LOOKUP, which then hits.
    - Beats arrive at ascending addresses (base, base+8, ...).
- Outputs valid only in their state: ifu_resp_valid only in LOOKUP&hit; mem_addr_valid only in MISS_AR; mem_r_ready only in MISS_R.
- Stability:
  - mem_addr is held stable while mem_addr_valid=1.
  - ifu_inst is held stable while ifu_resp_valid=1 and ifu_resp_ready=0.
- Requests and fences are blocked outside IDLE (ifu_req_ready=0, fence_ready=0). There is no fence during a refill, so a refill always completes and validates its line.
- Replacement: a conflict miss overwrites the line in place. There is no write-back.
- Reset values:
  - state=IDLE; all valid=0; cnt=0; req_addr=0.
  - Outputs: ifu_resp_valid=0, mem_addr_valid=0, mem_r_ready=0, ifu_inst=0 when not valid.
  - ifu_req_ready=1 and fence_ready=1 from the first cycle after rst deasserts.
- Reset mid-refill: the FSM returns to IDLE and the partially filled line stays invalid. The downstream master is reset by the same rst.
- Simultaneous events:
  - In IDLE, fence_valid and ifu_req_valid together: the fence wins and the request is taken the following cycle.
  - In LOOKUP, ifu_resp_ready coinciding with a new ifu_req_valid: not accepted until IDLE. Throughput is 1 fetch per 2 cycles on hits.

Test Plan:
1. Cold miss: after reset, fetch 0x8000_0004 -> mem_addr_valid with mem_addr=0x8000_0000, mem_len=1, mem_size=3, mem_burst=1, mem_if=1, mem_we=0. Feed beats 0x11112222_33334444 and 0x55556666_77778888 -> ifu_inst=0x11112222, resp_valid exactly 1 cycle after the last beat.
2. Hit: then fetch 0x8000_0008 -> no mem_addr_valid; resp_valid 1 cycle after acceptance; ifu_inst=0x77778888.
3. Conflict: fetch 0x8000_0400 (same idx, different tag with SETS=64, 16B lines) -> refill issued. Then refetch 0x8000_0000 -> miss again.
4. Fence: line 0x8000_0000 valid. Assert fence_valid together with ifu_req_valid -> fence_ready=1 and ifu_req_ready=0 that cycle. The next fetch of 0x8000_0000 misses.
5. Backpressure: mem_addr_ready held 0 for 5 cycles -> mem_addr stable. ifu_resp_ready held 0 for 3 cycles -> ifu_inst and resp_valid stable; no new request accepted.
6. Reset mid-refill: pulse rst after beat 0 -> all outputs at reset values. The same address then misses and issues a fresh refill.
